press_classifier: RTL



---
 rtl/press_classifier_pkg.sv | 31 +++
 rtl/press_classifier_event_timer.sv | 28 ++
 rtl/press_classifier.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/press_classifier_pkg.sv
// Shared state encoding and event codes for the button gesture classifier.
// Consumers decode ev_t codes; the FSM uses the 3-bit state constants.
package press_classifier_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HOLD1    = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_HOLD2    = 3'd3;
  localparam logic [2:0] ST_WAIT_REL = 3'd4;

  typedef logic [1:0] ev_t;

  localparam ev_t EV_NONE   = 2'd0;
  localparam ev_t EV_SHORT  = 2'd1;
  localparam ev_t EV_LONG   = 2'd2;
  localparam ev_t EV_DOUBLE = 2'd3;

  // One-hot decode of an event code as {double, long, short}.
  function automatic logic [2:0] ev_decode(input ev_t ev);
    logic [2:0] oh;
    oh = 3'b000;
    case (ev)
      EV_SHORT:  oh = 3'b001;
      EV_LONG:   oh = 3'b010;
      EV_DOUBLE: oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/press_classifier_event_timer.sv
// Interval up-counter with synchronous clear/enable; term flags cnt == limit-1.
// term is combinational from the count register and the selected limit.
module event_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             term
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term = (cnt == (limit - CNT_W'(1)));

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short/long/double single-cycle pulses.
// Events are registered (one cycle after the deciding edge); optional PRESS_CNT_EN adds press_count.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int LONG_CYC = 50,
  parameter int DBL_GAP  = 30,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press_pulse,
  input  logic       held,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       busy
`ifdef PRESS_CNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  localparam int MAX_CYC = (LONG_CYC > DBL_GAP) ? LONG_CYC : DBL_GAP;

  if ((2 ** CNT_W) <= MAX_CYC) begin : g_cnt_w_chk
    $error("press_classifier: CNT_W too narrow for LONG_CYC/DBL_GAP");
  end
  if (LONG_CYC < 2 || DBL_GAP < 2) begin : g_min_chk
    $error("press_classifier: LONG_CYC and DBL_GAP must be >= 2");
  end

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DBL_GAP);

  logic [2:0]       state, state_nxt;
  ev_t              ev_nxt;
  logic             tmr_clr, tmr_en, tmr_term;
  logic [CNT_W-1:0] tmr_limit;
  logic [2:0]       ev_oh;

  // Only the GAP state times against DBL_GAP; both hold states use LONG_CYC.
  assign tmr_limit = (state == ST_GAP) ? GAP_LIM : LONG_LIM;

  event_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .term  (tmr_term)
  );

  always_comb begin
    state_nxt = state;
    ev_nxt    = EV_NONE;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press_pulse) begin
          state_nxt = ST_HOLD1;
          tmr_clr   = 1'b1;
        end
      end
      ST_HOLD1: begin
        if (!held) begin
          state_nxt = ST_GAP;
          tmr_clr   = 1'b1;
        end else if (tmr_term) begin
          state_nxt = ST_WAIT_REL;
          ev_nxt    = EV_LONG;
          tmr_clr   = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_GAP: begin
        // A second press on the timeout edge still counts as a double press.
        if (press_pulse) begin
          state_nxt = ST_HOLD2;
          tmr_clr   = 1'b1;
        end else if (tmr_term) begin
          state_nxt = ST_IDLE;
          ev_nxt    = EV_SHORT;
          tmr_clr   = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_HOLD2: begin
        if (!held) begin
          state_nxt = ST_IDLE;
          ev_nxt    = EV_DOUBLE;
          tmr_clr   = 1'b1;
        end else if (tmr_term) begin
          state_nxt = ST_WAIT_REL;
          ev_nxt    = EV_DOUBLE;
          tmr_clr   = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!held) begin
          state_nxt = ST_IDLE;
          tmr_clr   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tmr_clr   = 1'b1;
      end
    endcase
  end

  assign ev_oh = ev_decode(ev_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
    end else begin
      state        <= state_nxt;
      short_press  <= ev_oh[0];
      long_press   <= ev_oh[1];
      double_press <= ev_oh[2];
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef PRESS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count <= 8'd0;
    end else if (ev_nxt != EV_NONE) begin
      press_count <= press_count + 8'd1;
    end
  end
`endif

endmodule
